// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : dual-write, N-read register file with write bypass and
//                      a per-register busy scoreboard.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int INDEX_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH  = 32,
  parameter int N_REGS          = 1 << INDEX_BIT_WIDTH,
  parameter int N_RD_PORTS      = 2,
  parameter int ZERO_REG        = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wrtEn0,
  input  logic                                  wrtEn1,
  input  logic [INDEX_BIT_WIDTH-1:0]            wrtIndex0,
  input  logic [INDEX_BIT_WIDTH-1:0]            wrtIndex1,
  input  logic [DATA_BIT_WIDTH-1:0]             dataIn0,
  input  logic [DATA_BIT_WIDTH-1:0]             dataIn1,
  input  logic [N_RD_PORTS*INDEX_BIT_WIDTH-1:0] rdIndex,
  output logic [N_RD_PORTS*DATA_BIT_WIDTH-1:0]  dataOut,
  output logic [N_RD_PORTS-1:0]                 rdBusy,
  input  logic                                  resvEn,
  input  logic [INDEX_BIT_WIDTH-1:0]            resvIndex,
  input  logic                                  flush
);

  logic [DATA_BIT_WIDTH-1:0] mem_q [N_REGS];
  logic [N_REGS-1:0]         busy_q;
  logic [N_REGS-1:0]         busy_d;

  logic w_we0;
  logic w_we1;
  logic w_resv;

  // An index is usable when in range and not the hardwired zero register.
  function automatic logic idx_ok(input logic [INDEX_BIT_WIDTH-1:0] idx);
    idx_ok = (32'(idx) < N_REGS) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  assign w_we0  = wrtEn0 && idx_ok(wrtIndex0);
  assign w_we1  = wrtEn1 && idx_ok(wrtIndex1);
  assign w_resv = resvEn && idx_ok(resvIndex);

  always_comb begin
    busy_d = busy_q;
    if (w_we0) busy_d[wrtIndex0] = 1'b0;
    if (w_we1) busy_d[wrtIndex1] = 1'b0;
    if (w_resv) busy_d[resvIndex] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (w_we0) mem_q[wrtIndex0] <= dataIn0;
      // Port 1 is assigned last so it wins a same-index collision.
      if (w_we1) mem_q[wrtIndex1] <= dataIn1;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < N_RD_PORTS; k++) begin : g_rd
    logic [INDEX_BIT_WIDTH-1:0] w_idx;
    logic                       w_ok;
    logic                       w_hit0;
    logic                       w_hit1;

    assign w_idx  = rdIndex[k*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH];
    assign w_ok   = idx_ok(w_idx);
    assign w_hit0 = w_we0 && (wrtIndex0 == w_idx);
    assign w_hit1 = w_we1 && (wrtIndex1 == w_idx);

    always_comb begin
      dataOut[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = '0;
      rdBusy[k] = 1'b0;
      if (w_ok) begin
        if (w_hit1)      dataOut[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = dataIn1;
        else if (w_hit0) dataOut[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = dataIn0;
        else             dataOut[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = mem_q[w_idx];
        // A same-cycle write satisfies the hazard through the bypass.
        rdBusy[k] = busy_q[w_idx] && !(w_hit0 || w_hit1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard : directed stimulus with queued expectations checked
//                         by a negedge monitor.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrtEn0, wrtEn1;
  logic [3:0]  wrtIndex0, wrtIndex1;
  logic [31:0] dataIn0, dataIn1;
  logic [7:0]  rdIndex;
  logic [63:0] dataOut;
  logic [1:0]  rdBusy;
  logic        resvEn;
  logic [3:0]  resvIndex;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .wrtEn0(wrtEn0), .wrtEn1(wrtEn1),
    .wrtIndex0(wrtIndex0), .wrtIndex1(wrtIndex1),
    .dataIn0(dataIn0), .dataIn1(dataIn1),
    .rdIndex(rdIndex), .dataOut(dataOut), .rdBusy(rdBusy),
    .resvEn(resvEn), .resvIndex(resvIndex), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: read outputs are always presented, so every negedge drains
  // whatever the driver queued for that cycle.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      cmp({e0.nm, ".p0.data"}, dataOut[31:0], e0.d);
      cmp({e0.nm, ".p0.busy"}, {31'd0, rdBusy[0]}, {31'd0, e0.b});
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      cmp({e1.nm, ".p1.data"}, dataOut[63:32], e1.d);
      cmp({e1.nm, ".p1.busy"}, {31'd0, rdBusy[1]}, {31'd0, e1.b});
    end
  end

  task automatic idle();
    reset = 0; wrtEn0 = 0; wrtEn1 = 0; wrtIndex0 = 0; wrtIndex1 = 0;
    dataIn0 = 0; dataIn1 = 0; resvEn = 0; resvIndex = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int k, input logic [3:0] idx, input logic [31:0] d,
                    input logic b, input string nm);
    if (k == 0) begin
      rdIndex[3:0] = idx;
      q0.push_back('{nm, d, b});
    end else begin
      rdIndex[7:4] = idx;
      q1.push_back('{nm, d, b});
    end
  endtask

  task automatic wr(input int p, input logic [3:0] idx, input logic [31:0] d);
    if (p == 0) begin wrtEn0 = 1; wrtIndex0 = idx; dataIn0 = d; end
    else        begin wrtEn1 = 1; wrtIndex1 = idx; dataIn1 = d; end
  endtask

  task automatic resv(input logic [3:0] idx);
    resvEn = 1; resvIndex = idx;
  endtask

  initial begin
    idle();
    rdIndex = 0;
    reset = 1;
    step(); step();
    idle();

    for (int i = 0; i < 16; i++) begin
      rd(0, 4'(i), 32'h0, 1'b0, "reset_rd");
      rd(1, 4'(15 - i), 32'h0, 1'b0, "reset_rd");
      step();
    end

    // Bypass then array read
    wr(0, 4'd3, 32'hDEADBEEF);
    rd(0, 4'd3, 32'hDEADBEEF, 1'b0, "bypass3");
    rd(1, 4'd4, 32'h0, 1'b0, "other4");
    step(); idle();
    rd(0, 4'd3, 32'hDEADBEEF, 1'b0, "array3");
    step();

    // Dual write collision
    wr(0, 4'd5, 32'h11); wr(1, 4'd5, 32'h22);
    rd(0, 4'd5, 32'h22, 1'b0, "coll_byp5");
    rd(1, 4'd3, 32'hDEADBEEF, 1'b0, "keep3");
    step(); idle();
    rd(0, 4'd5, 32'h22, 1'b0, "coll_arr5");
    step();

    // Reserve / release
    resv(4'd7);
    rd(0, 4'd7, 32'h0, 1'b0, "resv_same7");
    step(); idle();
    rd(0, 4'd7, 32'h0, 1'b1, "resv_next7");
    step();
    wr(1, 4'd7, 32'h77);
    rd(0, 4'd7, 32'h77, 1'b0, "release7");
    rd(1, 4'd7, 32'h77, 1'b0, "release7");
    step(); idle();
    rd(0, 4'd7, 32'h77, 1'b0, "after_rel7");
    step();
    resv(4'd7); wr(0, 4'd7, 32'h78);
    rd(0, 4'd7, 32'h78, 1'b0, "resv_wr7");
    step(); idle();
    rd(0, 4'd7, 32'h78, 1'b1, "resv_wins7");
    step();

    // Flush
    resv(4'd2); step();
    resv(4'd4);
    rd(0, 4'd2, 32'h0, 1'b1, "busy2");
    step();
    idle(); flush = 1; resv(4'd9); wr(0, 4'd8, 32'h88);
    rd(0, 4'd2, 32'h0, 1'b1, "pre_flush2");
    rd(1, 4'd4, 32'h0, 1'b1, "pre_flush4");
    step(); idle();
    rd(0, 4'd2, 32'h0, 1'b0, "flushed2");
    rd(1, 4'd4, 32'h0, 1'b0, "flushed4");
    step();
    rd(0, 4'd9, 32'h0, 1'b0, "flushed9");
    rd(1, 4'd7, 32'h78, 1'b0, "flushed7");
    step();
    rd(0, 4'd8, 32'h88, 1'b0, "flush_wr8");
    step();

    // Zero register
    wr(0, 4'd0, 32'hFFFFFFFF); wr(1, 4'd0, 32'hFFFFFFFF); resv(4'd0);
    rd(0, 4'd0, 32'h0, 1'b0, "zero_byp");
    rd(1, 4'd0, 32'h0, 1'b0, "zero_byp");
    step(); idle();
    rd(0, 4'd0, 32'h0, 1'b0, "zero_arr");
    step();

    // Reset during write and reserve
    wr(0, 4'd1, 32'hAB); step(); idle();
    rd(0, 4'd1, 32'hAB, 1'b0, "pre_rst1");
    step();
    reset = 1; wr(0, 4'd1, 32'h5); resv(4'd6);
    step(); idle();
    rd(0, 4'd1, 32'h0, 1'b0, "rst_wr1");
    rd(1, 4'd3, 32'h0, 1'b0, "rst_clr3");
    step();
    rd(0, 4'd6, 32'h0, 1'b0, "rst_resv6");
    rd(1, 4'd5, 32'h0, 1'b0, "rst_clr5");
    step();

    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
